writeback_buffer: RTL and testbench
===================================

# writeback_buffer

Drives the register file's single write port (W_addr, W_data, wr_enable) from two producers. The single-cycle ALU result path has strict priority. Long-latency results from the multiply/divide unit are queued in a small FIFO and drained into idle write-port cycles. The block also reports whether a register has a write still in flight, so the decode stage can stall on RAW hazards against queued results.

## Interface
- width, 64, data width; matches the register file width
- depth, 4, FIFO entries for long-latency results; power of two, ≥2
- clk  input  1  clock; all state updates on posedge
- reset  input  1  synchronous, active-high
- alu_valid  input  1  ALU result present this cycle
- alu_addr  input  5  ALU destination register
- alu_data  input  width  ALU result
- lu_valid  input  1  long-latency result offered
- lu_ready  output  1  FIFO can accept; equals !full
- lu_addr  input  5  long-latency destination register
- lu_data  input  width  long-latency result
- W_addr  output  5  register file write address (registered)
- W_data  output  width  register file write data (registered)
- wr_enable  output  1  register file write enable (registered)
- A_addr, B_addr  input  5 each  decode-stage source registers to check
- A_pending, B_pending  output  1 each  combinational; write to that register is still in flight
- count  output  $clog2(depth)+1  current FIFO occupancy

## Operation
- Push: on a posedge where lu_valid && lu_ready && lu_addr != 0, {lu_addr, lu_data} is appended at the FIFO tail.
- Dropped writes: a lu_valid && lu_ready with lu_addr == 0 completes the handshake and is discarded. An ALU result with alu_addr == 0 is also discarded.
- Output select, evaluated each cycle:
  - alu_valid && alu_addr != 0: the ALU result is registered to W_*, wr_enable=1, and the FIFO is not popped.
  - otherwise, FIFO not empty: the head is registered to W_*, wr_enable=1, and the head is popped.
  - otherwise: wr_enable=0, and W_addr/W_data hold their previous values.
- lu_ready depends only on the current full flag. When the FIFO is full, no push is taken, even in a cycle that pops.
- Simultaneous push and pop when not full: both occur, and count is unchanged.
- Pointers are log2(depth) bits and wrap modulo depth. Full/empty are derived from count.
- FIFO entries drain in arrival order. No ordering is enforced between the ALU path and FIFO entries. The pipeline must stall any instruction whose destination has A/B_pending set.
- A_pending is 1 iff A_addr != 0 and A_addr matches either of:
  - any valid FIFO entry;
  - W_addr while wr_enable=1.
  
  B_pending is defined identically using B_addr.
- Reset: count=0, pointers=0, wr_enable=0, W_addr=0, W_data=0, lu_ready=1 in the cycle after reset, A/B_pending=0. FIFO contents are discarded, and a push in the reset cycle is ignored.

## Timing
- ALU path latency: 1 cycle to the W_* outputs. The register file commits the value at the following posedge.
- Long-latency path, minimum latency: push at edge N, popped at edge N+1, W_* valid after edge N+1. Each ALU-priority cycle adds one cycle of delay.
- lu_ready and the pending outputs are valid in the same cycle as their inputs. There is no combinational path from lu_valid to lu_ready.
- Throughput: one register file write per cycle, sustained.

## Test plan
- Reset, then alu_valid=1, alu_addr=5'h01, alu_data=64'hdeadbeef for one cycle -> next cycle wr_enable=1, W_addr=1, W_data=deadbeef; following cycle wr_enable=0.
- With ALU idle, push lu entries (3, 64'h33), (4, 64'h44) on back-to-back cycles -> writes appear in order at edges N+1 and N+2; count goes 0,1,1,0.
- Hold alu_valid=1 with changing addresses while pushing depth+1 lu entries:
  - lu_ready drops after 4 accepted pushes and count=4.
  - the 5th entry is held until alu_valid drops.
  - then all 5 entries drain in order.
- Zero-register writes: alu_addr=0 and lu_addr=0 (with lu_valid) -> wr_enable stays 0, count stays 0, lu_ready stays 1.
- Pending: queue (5'h15, 64'hcafebabe) with ALU busy, set A_addr=5'h15, B_addr=5'h14 -> A_pending=1 and B_pending=0 while the entry is queued and through its wr_enable cycle; A_pending=0 afterwards.
- Reset mid-operation with count=3 -> next cycle count=0, wr_enable=0, lu_ready=1, and no queued entry is ever written.

Source files
------------

// File: rtl/writeback_buffer_if.sv
// Register-file write-port bus: ALU and long-latency producers in,
// registered write port plus RAW-hazard lookups out.
interface writeback_buffer_if #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic             alu_valid;
  logic [4:0]       alu_addr;
  logic [WIDTH-1:0] alu_data;
  logic             lu_valid;
  logic             lu_ready;
  logic [4:0]       lu_addr;
  logic [WIDTH-1:0] lu_data;
  logic [4:0]       W_addr;
  logic [WIDTH-1:0] W_data;
  logic             wr_enable;
  logic [4:0]       A_addr;
  logic [4:0]       B_addr;
  logic             A_pending;
  logic             B_pending;
  logic [CW-1:0]    count;

  modport master (
    output alu_valid, alu_addr, alu_data, lu_valid, lu_addr, lu_data, A_addr, B_addr,
    input  lu_ready, W_addr, W_data, wr_enable, A_pending, B_pending, count
  );

  modport slave (
    input  alu_valid, alu_addr, alu_data, lu_valid, lu_addr, lu_data, A_addr, B_addr,
    output lu_ready, W_addr, W_data, wr_enable, A_pending, B_pending, count
  );
endinterface

// File: rtl/writeback_buffer.sv
// Single register-file write port shared by a priority ALU path and a
// FIFO of long-latency results that drains into idle write cycles.
module writeback_buffer #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  writeback_buffer_if.slave bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [4:0]       mem_addr [DEPTH];
  logic [WIDTH-1:0] mem_data [DEPTH];
  logic [PW-1:0]    wr_ptr, rd_ptr;
  logic [CW-1:0]    count_q;
  logic [4:0]       w_addr_q;
  logic [WIDTH-1:0] w_data_q;
  logic             wr_en_q;

  logic full, empty, push, pop, alu_take;
  logic [DEPTH-1:0] entry_vld;
  logic a_hit, b_hit;

  assign full     = (count_q == CW'(DEPTH));
  assign empty    = (count_q == '0);
  assign alu_take = bus.alu_valid && (bus.alu_addr != 5'd0);
  // Zero-register results complete the handshake but are never stored.
  assign push     = bus.lu_valid && !full && (bus.lu_addr != 5'd0);
  assign pop      = !alu_take && !empty;

  always_comb begin
    entry_vld = '0;
    a_hit     = wr_en_q && (w_addr_q == bus.A_addr);
    b_hit     = wr_en_q && (w_addr_q == bus.B_addr);
    for (int i = 0; i < DEPTH; i++) begin
      // Slot i is live when its distance from the head is below occupancy.
      entry_vld[i] = {1'b0, PW'(i) - rd_ptr} < count_q;
      if (entry_vld[i] && mem_addr[i] == bus.A_addr) a_hit = 1'b1;
      if (entry_vld[i] && mem_addr[i] == bus.B_addr) b_hit = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count_q  <= '0;
      wr_en_q  <= 1'b0;
      w_addr_q <= '0;
      w_data_q <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count_q <= count_q + CW'(push) - CW'(pop);
      wr_en_q <= alu_take || pop;
      if (alu_take) begin
        w_addr_q <= bus.alu_addr;
        w_data_q <= bus.alu_data;
      end else if (pop) begin
        w_addr_q <= mem_addr[rd_ptr];
        w_data_q <= mem_data[rd_ptr];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push && !reset) begin
      mem_addr[wr_ptr] <= bus.lu_addr;
      mem_data[wr_ptr] <= bus.lu_data;
    end
  end

  assign bus.lu_ready  = !full;
  assign bus.W_addr    = w_addr_q;
  assign bus.W_data    = w_data_q;
  assign bus.wr_enable = wr_en_q;
  assign bus.count     = count_q;
  assign bus.A_pending = (bus.A_addr != 5'd0) && a_hit;
  assign bus.B_pending = (bus.B_addr != 5'd0) && b_hit;
endmodule

// File: tb/tb_writeback_buffer.sv
// Directed self-checking bench for writeback_buffer: inputs change on the
// falling edge, outputs are checked on the following falling edge.
module tb_writeback_buffer;
  logic clk = 1'b0;
  logic reset;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  writeback_buffer_if #(.WIDTH(64), .DEPTH(4)) bus ();
  writeback_buffer #(.WIDTH(64), .DEPTH(4)) dut (.clk(clk), .reset(reset), .bus(bus));

  task automatic step();
    @(negedge clk);
  endtask

  task automatic idle();
    bus.alu_valid = 1'b0; bus.alu_addr = '0; bus.alu_data = '0;
    bus.lu_valid  = 1'b0; bus.lu_addr  = '0; bus.lu_data  = '0;
    bus.A_addr    = '0;   bus.B_addr   = '0;
  endtask

  task automatic test_reset();
    idle();
    reset = 1'b1;
    step(); step();
    checks++; if (bus.wr_enable !== 1'b0) begin errors++; $display("FAIL reset_wren got %0b exp 0", bus.wr_enable); end
    checks++; if (bus.count !== 3'd0) begin errors++; $display("FAIL reset_count got %0d exp 0", bus.count); end
    checks++; if (bus.lu_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %0b exp 1", bus.lu_ready); end
    checks++; if (bus.W_addr !== 5'd0 || bus.W_data !== 64'd0) begin errors++; $display("FAIL reset_w got %h/%h exp 0/0", bus.W_addr, bus.W_data); end
    checks++; if (bus.A_pending !== 1'b0 || bus.B_pending !== 1'b0) begin errors++; $display("FAIL reset_pend got %b%b exp 00", bus.A_pending, bus.B_pending); end
    reset = 1'b0;
  endtask

  task automatic test_alu();
    bus.alu_valid = 1'b1; bus.alu_addr = 5'h01; bus.alu_data = 64'hdeadbeef;
    bus.A_addr = 5'h01;
    step();
    bus.alu_valid = 1'b0;
    checks++; if (bus.wr_enable !== 1'b1) begin errors++; $display("FAIL alu_wren got %0b exp 1", bus.wr_enable); end
    checks++; if (bus.W_addr !== 5'h01 || bus.W_data !== 64'hdeadbeef) begin errors++; $display("FAIL alu_w got %h/%h exp 01/deadbeef", bus.W_addr, bus.W_data); end
    checks++; if (bus.A_pending !== 1'b1) begin errors++; $display("FAIL alu_pend got %0b exp 1", bus.A_pending); end
    step();
    checks++; if (bus.wr_enable !== 1'b0) begin errors++; $display("FAIL alu_wren_off got %0b exp 0", bus.wr_enable); end
    checks++; if (bus.A_pending !== 1'b0) begin errors++; $display("FAIL alu_pend_off got %0b exp 0", bus.A_pending); end
    idle();
  endtask

  task automatic test_lu_order();
    bus.lu_valid = 1'b1; bus.lu_addr = 5'd3; bus.lu_data = 64'h33;
    step();
    checks++; if (bus.count !== 3'd1 || bus.wr_enable !== 1'b0) begin errors++; $display("FAIL lu_first count %0d wren %0b exp 1/0", bus.count, bus.wr_enable); end
    bus.lu_addr = 5'd4; bus.lu_data = 64'h44;
    step();
    bus.lu_valid = 1'b0;
    checks++; if (bus.count !== 3'd1 || bus.wr_enable !== 1'b1 || bus.W_addr !== 5'd3 || bus.W_data !== 64'h33)
      begin errors++; $display("FAIL lu_w3 count %0d wren %0b W %h/%h exp 1/1 03/33", bus.count, bus.wr_enable, bus.W_addr, bus.W_data); end
    step();
    checks++; if (bus.count !== 3'd0 || bus.wr_enable !== 1'b1 || bus.W_addr !== 5'd4 || bus.W_data !== 64'h44)
      begin errors++; $display("FAIL lu_w4 count %0d wren %0b W %h/%h exp 0/1 04/44", bus.count, bus.wr_enable, bus.W_addr, bus.W_data); end
    step();
    checks++; if (bus.wr_enable !== 1'b0) begin errors++; $display("FAIL lu_idle got %0b exp 0", bus.wr_enable); end
    idle();
  endtask

  task automatic test_full();
    int exp_cnt [5] = '{3, 3, 2, 1, 0};
    // Entry k is (8+k, 0x100+k); ALU writes to 16+c each busy cycle.
    for (int c = 0; c < 6; c++) begin
      bus.alu_valid = 1'b1; bus.alu_addr = 5'(16 + c); bus.alu_data = 64'(c);
      bus.lu_valid  = 1'b1;
      bus.lu_addr   = 5'(8 + (c < 4 ? c : 4)); bus.lu_data = 64'(256 + (c < 4 ? c : 4));
      checks++; if (bus.lu_ready !== (c < 4)) begin errors++; $display("FAIL full_ready c=%0d got %0b exp %0b", c, bus.lu_ready, c < 4); end
      step();
      checks++; if (bus.W_addr !== 5'(16 + c) || bus.W_data !== 64'(c)) begin errors++; $display("FAIL full_alu c=%0d W %h/%h", c, bus.W_addr, bus.W_data); end
      checks++; if (bus.count !== 3'(c < 4 ? c + 1 : 4)) begin errors++; $display("FAIL full_count c=%0d got %0d exp %0d", c, bus.count, c < 4 ? c + 1 : 4); end
    end
    bus.alu_valid = 1'b0;
    for (int k = 0; k < 5; k++) begin
      step();
      if (k == 1) bus.lu_valid = 1'b0;
      checks++; if (bus.wr_enable !== 1'b1 || bus.W_addr !== 5'(8 + k) || bus.W_data !== 64'(256 + k))
        begin errors++; $display("FAIL drain k=%0d wren %0b W %h/%h exp 1 %h/%h", k, bus.wr_enable, bus.W_addr, bus.W_data, 8 + k, 256 + k); end
      checks++; if (bus.count !== 3'(exp_cnt[k])) begin errors++; $display("FAIL drain_count k=%0d got %0d exp %0d", k, bus.count, exp_cnt[k]); end
    end
    step();
    checks++; if (bus.wr_enable !== 1'b0) begin errors++; $display("FAIL drain_idle got %0b exp 0", bus.wr_enable); end
    idle();
  endtask

  task automatic test_zero();
    bus.alu_valid = 1'b1; bus.alu_addr = 5'd0; bus.alu_data = 64'h77;
    bus.lu_valid  = 1'b1; bus.lu_addr  = 5'd0; bus.lu_data  = 64'h88;
    for (int c = 0; c < 2; c++) begin
      step();
      checks++; if (bus.wr_enable !== 1'b0 || bus.count !== 3'd0 || bus.lu_ready !== 1'b1)
        begin errors++; $display("FAIL zero c=%0d wren %0b count %0d ready %0b exp 0/0/1", c, bus.wr_enable, bus.count, bus.lu_ready); end
    end
    idle();
    step();
    checks++; if (bus.wr_enable !== 1'b0) begin errors++; $display("FAIL zero_after got %0b exp 0", bus.wr_enable); end
  endtask

  task automatic test_pending();
    bus.A_addr = 5'h15; bus.B_addr = 5'h14;
    bus.alu_valid = 1'b1; bus.alu_addr = 5'd2; bus.alu_data = 64'h2;
    bus.lu_valid  = 1'b1; bus.lu_addr  = 5'h15; bus.lu_data = 64'hcafebabe;
    step();
    bus.lu_valid = 1'b0;
    checks++; if (bus.count !== 3'd1 || bus.A_pending !== 1'b1 || bus.B_pending !== 1'b0)
      begin errors++; $display("FAIL pend_q1 count %0d A %0b B %0b exp 1/1/0", bus.count, bus.A_pending, bus.B_pending); end
    step();
    bus.alu_valid = 1'b0;
    checks++; if (bus.A_pending !== 1'b1 || bus.B_pending !== 1'b0) begin errors++; $display("FAIL pend_q2 A %0b B %0b exp 1/0", bus.A_pending, bus.B_pending); end
    step();
    checks++; if (bus.wr_enable !== 1'b1 || bus.W_addr !== 5'h15 || bus.W_data !== 64'hcafebabe || bus.count !== 3'd0)
      begin errors++; $display("FAIL pend_w wren %0b W %h/%h count %0d exp 1 15/cafebabe 0", bus.wr_enable, bus.W_addr, bus.W_data, bus.count); end
    checks++; if (bus.A_pending !== 1'b1 || bus.B_pending !== 1'b0) begin errors++; $display("FAIL pend_wcyc A %0b B %0b exp 1/0", bus.A_pending, bus.B_pending); end
    step();
    checks++; if (bus.A_pending !== 1'b0) begin errors++; $display("FAIL pend_done A %0b exp 0", bus.A_pending); end
    idle();
  endtask

  task automatic test_reset_mid();
    for (int c = 0; c < 3; c++) begin
      bus.alu_valid = 1'b1; bus.alu_addr = 5'(20 + c); bus.alu_data = 64'(c);
      bus.lu_valid  = 1'b1; bus.lu_addr  = 5'(9 + c);  bus.lu_data  = 64'(64'h900 + c);
      step();
    end
    checks++; if (bus.count !== 3'd3) begin errors++; $display("FAIL mid_count got %0d exp 3", bus.count); end
    idle();
    bus.lu_valid = 1'b1; bus.lu_addr = 5'd12; bus.lu_data = 64'hc;
    reset = 1'b1;
    step();
    reset = 1'b0;
    bus.lu_valid = 1'b0;
    checks++; if (bus.count !== 3'd0 || bus.wr_enable !== 1'b0 || bus.lu_ready !== 1'b1)
      begin errors++; $display("FAIL mid_reset count %0d wren %0b ready %0b exp 0/0/1", bus.count, bus.wr_enable, bus.lu_ready); end
    for (int c = 0; c < 4; c++) begin
      step();
      checks++; if (bus.wr_enable !== 1'b0 || bus.count !== 3'd0) begin errors++; $display("FAIL mid_nowrite c=%0d wren %0b count %0d exp 0/0", c, bus.wr_enable, bus.count); end
    end
  endtask

  initial begin
    reset = 1'b1;
    idle();
    step();
    test_reset();
    test_alu();
    test_lu_order();
    test_full();
    test_zero();
    test_pending();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
